// File: rtl/aes_sub_bytes_seq.sv
// Sequential forward AES SubBytes: BYTES_PER_CYCLE shared S-box lanes walk
// across the 128-bit state in place, with valid/ready on both sides.

module aes_sbox_lane (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];
endmodule

module aes_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int C  = 16 / BYTES_PER_CYCLE;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                               state, state_nxt;
  logic [15:0][7:0]                     st, st_sub;
  logic [IW-1:0]                        idx;
  logic [BYTES_PER_CYCLE-1:0][7:0]      lane_in, lane_out;
  logic                                 last, accept;

  // byte k sits at st[15-k] so byte 0 is the MSB byte of the bus
  function automatic logic [3:0] byte_pos(input logic [IW-1:0] i, input int l);
    return 4'(15 - (int'(i) * BYTES_PER_CYCLE + l));
  endfunction

  assign last   = (idx == IW'(C - 1));
  assign accept = in_valid && in_ready;

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    assign lane_in[l] = st[byte_pos(idx, l)];
    aes_sbox_lane u_sbox (.din(lane_in[l]), .dout(lane_out[l]));
  end

  always_comb begin
    st_sub = st;
    for (int l = 0; l < BYTES_PER_CYCLE; l++)
      st_sub[byte_pos(idx, l)] = lane_out[l];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        // output handoff and next accept share one edge
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= '0;
      idx <= '0;
    end else if (accept) begin
      st  <= in_data;
      idx <= '0;
    end else if (state == BUSY) begin
      st  <= st_sub;
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_data  = st;
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: three instances (4, 1, 16 bytes/cycle), a
// GF(2^8)-derived reference S-box, and a scoreboard on the default instance.

module tb_aes_sub_bytes_seq;
  logic         clk = 1'b0;
  logic         reset;
  logic         iv   [3];
  logic         ordy [3];
  logic [127:0] idat [3];
  logic         irdy [3];
  logic         ov   [3];
  logic         bsy  [3];
  logic [127:0] odat [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    aes_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(iv[g]), .in_ready(irdy[g]), .in_data(idat[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(odat[g]),
      .busy(bsy[g])
    );
  end

  int n_chk = 0, n_fail = 0, n_pop = 0, cyc = 0;
  logic [7:0]   sb_ref [256];
  logic [7:0]   isb_ref[256];
  logic [127:0] exp_q[$];
  logic [127:0] next_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_block(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sb_ref[d[127-8*k -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_block(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = isb_ref[d[127-8*k -: 8]];
    return r;
  endfunction

  // scoreboard on instance 0: push at accept, pop at output handshake
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (ov[0] && ordy[0]) begin
        n_pop++;
        if (exp_q.size() == 0) check("sb_unexpected_output", odat[0], 128'hx);
        else check("sb_out", odat[0], exp_q.pop_front());
      end
      if (iv[0] && irdy[0]) exp_q.push_back(next_exp);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int i, input logic [127:0] d, input logic [127:0] e);
    int n = 0;
    idat[i] = d;
    iv[i]   = 1'b1;
    if (i == 0) next_exp = e;
    @(negedge clk);
    while (!irdy[i] && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout", 128'(n), 128'(0));
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_out(input int i, input int lat);
    int c = 0;
    while (!ov[i] && c < 100) begin tick(); c++; end
    check($sformatf("latency_dut%0d", i), 128'(c), 128'(lat));
  endtask

  task automatic take(input int i);
    ordy[i] = 1'b1;
    tick();
    ordy[i] = 1'b0;
    check($sformatf("out_valid_drop_dut%0d", i), 128'(ov[i]), 128'(0));
  endtask

  typedef struct { logic [127:0] din; logic [127:0] dout; } vec_t;
  vec_t vecs[4];

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] hold, d, b2b_in[3], b2b_out[3];
    int lats[3], acc_cyc, prev_cyc, pop0, seen_ov;

    for (int x = 0; x < 256; x++) sb_ref[x] = sbox_calc(8'(x));
    for (int x = 0; x < 256; x++) isb_ref[sb_ref[x]] = 8'(x);

    vecs[0] = '{128'h0, {16{8'h63}}};
    vecs[1] = '{APPB_IN, APPB_OUT};
    vecs[2] = '{{16{8'hff}}, {16{8'h16}}};
    vecs[3] = '{{16{8'h53}}, {16{8'hed}}};
    lats = '{4, 16, 1};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; idat[i] = '0;
    end
    next_exp = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 128'(ov[0]), 128'(0));
    check("rst_busy",      128'(bsy[0]), 128'(0));
    check("rst_in_ready",  128'(irdy[0]), 128'(1));
    check("rst_out_data",  odat[0], 128'h0);
    tick();

    // table vectors on the default instance
    for (int v = 0; v < 4; v++) begin
      send(0, vecs[v].din, vecs[v].dout);
      check("busy_after_accept", 128'(bsy[0]), 128'(1));
      wait_out(0, 4);
      check("tbl_out", odat[0], vecs[v].dout);
      take(0);
    end

    // Appendix B on the 1- and 16-lane instances
    for (int i = 1; i < 3; i++) begin
      send(i, APPB_IN, APPB_OUT);
      wait_out(i, lats[i]);
      check($sformatf("appb_dut%0d", i), odat[i], APPB_OUT);
      take(i);
    end

    // backpressure: 7 cycles with out_ready low
    send(0, APPB_IN, APPB_OUT);
    wait_out(0, 4);
    hold = odat[0];
    for (int c = 0; c < 7; c++) begin
      tick();
      check("bp_stable",   odat[0], hold);
      check("bp_in_ready", 128'(irdy[0]), 128'(0));
      check("bp_busy",     128'(bsy[0]), 128'(0));
      check("bp_valid",    128'(ov[0]), 128'(1));
    end
    take(0);

    // back-to-back streaming with out_ready held high
    b2b_in  = '{{16{8'h00}}, {16{8'hff}}, {16{8'h53}}};
    b2b_out = '{{16{8'h63}}, {16{8'h16}}, {16{8'hed}}};
    pop0 = n_pop;
    prev_cyc = 0;
    ordy[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send(0, b2b_in[b], b2b_out[b]);
      acc_cyc = cyc;
      if (b > 0) check("b2b_interval", 128'(acc_cyc - prev_cyc), 128'(5));
      prev_cyc = acc_cyc;
    end
    for (int c = 0; c < 20 && (n_pop - pop0) < 3; c++) tick();
    tick(); tick();
    check("b2b_count", 128'(n_pop - pop0), 128'(3));
    ordy[0] = 1'b0;

    // exhaustive sweep of all 256 byte values, plus inverse round trip
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = 8'(16*j + k);
      send(0, d, sub_block(d));
      wait_out(0, 4);
      check($sformatf("sweep_inv_%0d", j), inv_block(odat[0]), d);
      take(0);
    end

    // reset while a block is half processed
    send(0, APPB_IN, APPB_OUT);
    tick();
    check("mid_busy", 128'(bsy[0]), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 128'(ov[0]), 128'(0));
    check("async_rst_busy",  128'(bsy[0]), 128'(0));
    check("async_rst_data",  odat[0], 128'h0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(irdy[0]), 128'(1));
    seen_ov = 0;
    ordy[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ov[0]) seen_ov++;
    end
    ordy[0] = 1'b0;
    check("no_stale_output", 128'(seen_ov), 128'(0));
    check("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
